btle_rx_pkt_buffer: RTL and testbench
=====================================

BTLE_RX_PKT_BUFFER -- requirements
Module: btle_rx_pkt_buffer

Interface
REQ-001 The block SHALL have parameter OCTET_DEPTH, default 256: octet storage depth; power of two, 16..4096.
REQ-002 The block SHALL have parameter PKT_SLOTS, default 4: descriptor FIFO depth; power of two, 2..16.
REQ-003 The block SHALL have parameter DROP_CRC_FAIL, default 1: 1 discards packets ending with crc_ok=0; 0 keeps them, flagged.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- hit_flag  in  1  access address detected; packet start
- octet  in  8  decoded octet
- octet_valid  in  1  octet strobe
- decode_end  in  1  packet end
- crc_ok  in  1  CRC result, valid with decode_end
- pkt_avail  out  1  at least one committed packet stored
- pkt_len  out  8  octet count of head packet
- pkt_crc_ok  out  1  CRC flag of head packet
- rd_octet  out  8  read data
- rd_valid  out  1  read data valid
- rd_ready  in  1  consumer accepts rd_octet
- rd_last  out  1  final octet of head packet
- drop_count  out  16  packets discarded, saturating
- overflow  out  1  sticky: a packet was lost for lack of space

Function
REQ-005 The write FSM SHALL have states IDLE, CAPTURE and DISCARD.
REQ-006 On hit_flag in IDLE, the FSM SHALL latch pkt_start=wr_ptr and len=0, then go to CAPTURE; if the descriptor FIFO is full, it SHALL go to DISCARD instead.
REQ-007 In CAPTURE, octet_valid SHALL write mem[wr_ptr]=octet, increment wr_ptr modulo OCTET_DEPTH, and increment len.
REQ-008 If an octet arrives in CAPTURE when used==OCTET_DEPTH, or when len==255, the FSM SHALL rewind wr_ptr to pkt_start, set overflow, increment drop_count, and go to DISCARD.
REQ-009 On decode_end in CAPTURE: if crc_ok==1 or DROP_CRC_FAIL==0, the block SHALL push descriptor {pkt_start, len, crc_ok}; otherwise it SHALL rewind wr_ptr and increment drop_count; the FSM SHALL then go to IDLE.
REQ-010 On decode_end in CAPTURE with len==0, the block SHALL push nothing and SHALL NOT count a drop.
REQ-011 In DISCARD, octets SHALL be ignored and decode_end SHALL return the FSM to IDLE.
REQ-012 hit_flag in CAPTURE or DISCARD SHALL abandon the current packet (rewind, no drop count) and restart per REQ-006.
REQ-013 If octet_valid and decode_end occur in the same cycle, the octet SHALL be written and counted first.
REQ-014 used SHALL count committed plus in-capture octets; rewinds SHALL subtract the abandoned len.
REQ-015 Read side: when pkt_avail=1, the block SHALL present the head descriptor on pkt_len/pkt_crc_ok and stream mem[pkt_start..] on rd_octet.
REQ-016 rd_valid SHALL follow a valid/ready handshake: a transfer occurs when rd_valid&&rd_ready, and rd_octet SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-017 rd_octet SHALL come from registered RAM; the first rd_valid of a packet SHALL appear no later than 2 cycles after pkt_avail rises.
REQ-018 rd_last SHALL be 1 on the pkt_len-th octet; on its transfer the descriptor SHALL be popped and pkt_len octets freed from used.
REQ-019 Simultaneous write, commit, read and pop in one cycle SHALL be supported without loss; freed space SHALL be usable on the next cycle.
REQ-020 Pointers SHALL wrap modulo OCTET_DEPTH and modulo PKT_SLOTS; packets may straddle the wrap.
REQ-021 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-022 While rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, pointers=0, used=0, descriptor FIFO empty.
REQ-023 While rst_n=0, all outputs SHALL be 0, including drop_count and overflow.
REQ-024 Memory contents SHALL NOT need reset.
REQ-025 Reset asserted mid-capture or mid-read SHALL discard all packets; after release, the block SHALL behave as freshly reset.
REQ-026 Release of rst_n SHALL be synchronised to clk.

Verification
REQ-027 hit, octets 0x40 0x05 0xAA 0xBB 0xCC 0xDD 0xEE, decode_end crc_ok=1, rd_ready=1 -> pkt_len=7, pkt_crc_ok=1, same 7 octets out, rd_last on 0xEE, pkt_avail=0 after.
REQ-028 DROP_CRC_FAIL=1, 10-octet packet with crc_ok=0 -> nothing readable, drop_count=1, used=0; DROP_CRC_FAIL=0 -> readable with pkt_crc_ok=0.
REQ-029 OCTET_DEPTH=16, rd_ready=0, packets of 10 then 10 octets -> first kept, second dropped, overflow=1, drop_count=1.
REQ-030 PKT_SLOTS=2, three 3-octet packets with rd_ready=0 -> two stored, third dropped; raising rd_ready reads both in order.
REQ-031 Continuous 12-octet packets with wr_ptr starting at 250 (DEPTH 256), random rd_ready -> data intact across the wrap, no drops.
REQ-032 rst_n pulsed low mid-capture with one packet stored -> all outputs 0 immediately; next packet captured correctly.

Source files
------------

// File: rtl/btle_rx_pkt_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btle_rx_pkt_buffer_if                                      |
// | Description : Read-side stream of the BTLE receive packet buffer. The    |
// |               buffer is the master and presents the head packet          |
// |               descriptor plus a valid/ready octet stream. The consumer   |
// |               is the slave.                                              |
// |   pkt_avail  : at least one committed packet is stored                   |
// |   pkt_len    : octet count of the head packet                            |
// |   pkt_crc_ok : CRC flag of the head packet                               |
// |   rd_octet   : read data, held while rd_valid=1 and rd_ready=0           |
// |   rd_valid   : read data valid                                           |
// |   rd_ready   : consumer accepts rd_octet                                 |
// |   rd_last    : final octet of the head packet                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface btle_rx_pkt_buffer_if;
  logic       pkt_avail;
  logic [7:0] pkt_len;
  logic       pkt_crc_ok;
  logic [7:0] rd_octet;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_last;

  modport master (
    output pkt_avail, pkt_len, pkt_crc_ok, rd_octet, rd_valid, rd_last,
    input  rd_ready
  );

  modport slave (
    input  pkt_avail, pkt_len, pkt_crc_ok, rd_octet, rd_valid, rd_last,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/btle_rx_pkt_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btle_rx_pkt_buffer                                         |
// | Description : Buffers decoded BTLE packets in a circular octet memory    |
// |               with a descriptor FIFO, and streams committed packets out  |
// |               in arrival order.                                          |
// |   clk, rst_n       : clock, asynchronous active-low reset                |
// |   hit_flag         : packet start (access address detected)              |
// |   octet/octet_valid: decoded octet stream                                |
// |   decode_end/crc_ok: packet end and its CRC result                       |
// |   rd_if            : read-side descriptor + valid/ready octet stream     |
// |   drop_count       : discarded packets, saturating                       |
// |   overflow         : sticky, a packet was lost for lack of space         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module btle_rx_pkt_buffer #(
  parameter int OCTET_DEPTH   = 256,
  parameter int PKT_SLOTS     = 4,
  parameter int DROP_CRC_FAIL = 1
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  hit_flag,
  input  wire  [7:0]           octet,
  input  wire                  octet_valid,
  input  wire                  decode_end,
  input  wire                  crc_ok,
  btle_rx_pkt_buffer_if.master rd_if,
  output logic [15:0]          drop_count,
  output logic                 overflow
);
  localparam int AW = $clog2(OCTET_DEPTH);
  localparam int UW = AW + 1;
  localparam int SW = $clog2(PKT_SLOTS);
  localparam int CW = SW + 1;
  localparam logic [UW-1:0] USED_FULL  = UW'(OCTET_DEPTH);
  localparam logic [CW-1:0] SLOTS_FULL = CW'(PKT_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  // Reset asserts asynchronously, releases synchronously to clk.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       arst_n;

  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe_q <= '0;
    else        rst_pipe_q <= rst_pipe_d;
  end

  assign arst_n = rst_pipe_q[1];

  wr_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d;
  logic [7:0]    len_q, len_d;
  logic [UW-1:0] used_q, used_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          overflow_q, overflow_d;
  logic [SW-1:0] desc_wr_q, desc_wr_d, desc_rd_q, desc_rd_d;
  logic [CW-1:0] desc_cnt_q, desc_cnt_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

  logic [7:0]    mem_q [OCTET_DEPTH];
  logic [7:0]    mem_rdata_q;
  logic [AW-1:0] desc_start_q [PKT_SLOTS];
  logic [7:0]    desc_len_q   [PKT_SLOTS];
  logic          desc_crc_q   [PKT_SLOTS];

  logic          mem_we, wr_inc, push, pop, fetch_en, drop_inc, fifo_full, avail;
  logic [7:0]    rewind_len, push_len, head_len;
  logic [AW-1:0] head_start, rd_addr;
  logic          head_crc;

  assign fifo_full  = (desc_cnt_q == SLOTS_FULL);
  assign avail      = (desc_cnt_q != '0);
  assign head_start = desc_start_q[desc_rd_q];
  assign head_len   = desc_len_q[desc_rd_q];
  assign head_crc   = desc_crc_q[desc_rd_q];

  // Write FSM
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    len_d       = len_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;
    wr_inc      = 1'b0;
    push        = 1'b0;
    push_len    = len_q;
    drop_inc    = 1'b0;
    rewind_len  = '0;
    if (hit_flag) begin
      // A new start abandons any packet in progress. Outside CAPTURE the
      // write pointer already sits at the first free octet.
      if (state_q == ST_CAPTURE) begin
        wr_ptr_d    = pkt_start_q;
        rewind_len  = len_q;
        pkt_start_d = pkt_start_q;
      end else begin
        pkt_start_d = wr_ptr_q;
      end
      len_d = '0;
      // No descriptor slot: the packet is lost for lack of space.
      if (fifo_full) begin
        state_d    = ST_DISCARD;
        drop_inc   = 1'b1;
        overflow_d = 1'b1;
      end else begin
        state_d = ST_CAPTURE;
      end
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (octet_valid && (used_q == USED_FULL || len_q == 8'hFF)) begin
            wr_ptr_d   = pkt_start_q;
            rewind_len = len_q;
            overflow_d = 1'b1;
            drop_inc   = 1'b1;
            state_d    = decode_end ? ST_IDLE : ST_DISCARD;
          end else begin
            if (octet_valid) begin
              mem_we   = 1'b1;
              wr_inc   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              len_d    = len_q + 8'd1;
            end
            // len_d already includes an octet arriving with decode_end.
            if (decode_end) begin
              state_d  = ST_IDLE;
              push_len = len_d;
              if (len_d != 8'd0) begin
                if (crc_ok || DROP_CRC_FAIL == 0) begin
                  push = 1'b1;
                end else begin
                  wr_ptr_d   = pkt_start_q;
                  rewind_len = len_d;
                  drop_inc   = 1'b1;
                end
              end
            end
          end
        end
        ST_DISCARD: if (decode_end) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // Read side: a one-octet output register fed by a synchronous RAM read.
  // A fetch only happens when the register is empty or being consumed, so
  // rd_octet stays stable while stalled.
  always_comb begin
    fetch_en   = avail && (rd_idx_q != head_len) && (!rd_valid_q || rd_if.rd_ready);
    pop        = rd_valid_q && rd_if.rd_ready && rd_last_q;
    rd_addr    = head_start + AW'(rd_idx_q);
    rd_idx_d   = rd_idx_q;
    if (pop)           rd_idx_d = '0;
    else if (fetch_en) rd_idx_d = rd_idx_q + 8'd1;
    rd_valid_d = fetch_en || (rd_valid_q && !rd_if.rd_ready);
    rd_last_d  = fetch_en ? (rd_idx_q + 8'd1 == head_len) : rd_last_q;
  end

  // Occupancy and descriptor FIFO bookkeeping
  always_comb begin
    used_d       = used_q + UW'(wr_inc) - UW'(rewind_len) - (pop ? UW'(head_len) : '0);
    desc_wr_d    = push ? desc_wr_q + 1'b1 : desc_wr_q;
    desc_rd_d    = pop ? desc_rd_q + 1'b1 : desc_rd_q;
    desc_cnt_d   = desc_cnt_q + CW'(push) - CW'(pop);
    drop_count_d = (drop_inc && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pkt_start_q  <= '0;
      len_q        <= '0;
      used_q       <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      desc_wr_q    <= '0;
      desc_rd_q    <= '0;
      desc_cnt_q   <= '0;
      rd_idx_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pkt_start_q  <= pkt_start_d;
      len_q        <= len_d;
      used_q       <= used_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      desc_wr_q    <= desc_wr_d;
      desc_rd_q    <= desc_rd_d;
      desc_cnt_q   <= desc_cnt_d;
      rd_idx_q     <= rd_idx_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
    end
  end

  // Storage arrays carry no reset; their contents are only observed through
  // state that is reset.
  always_ff @(posedge clk) begin
    if (mem_we)   mem_q[wr_ptr_q] <= octet;
    if (fetch_en) mem_rdata_q     <= mem_q[rd_addr];
    if (push) begin
      desc_start_q[desc_wr_q] <= pkt_start_q;
      desc_len_q[desc_wr_q]   <= push_len;
      desc_crc_q[desc_wr_q]   <= crc_ok;
    end
  end

  assign rd_if.pkt_avail  = avail;
  assign rd_if.pkt_len    = avail ? head_len : 8'd0;
  assign rd_if.pkt_crc_ok = avail && head_crc;
  assign rd_if.rd_octet   = rd_valid_q ? mem_rdata_q : 8'd0;
  assign rd_if.rd_valid   = rd_valid_q;
  assign rd_if.rd_last    = rd_valid_q && rd_last_q;
  assign drop_count       = drop_count_q;
  assign overflow         = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_btle_rx_pkt_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_btle_rx_pkt_buffer                                      |
// | Description : Self-checking bench. dut0 uses default parameters,         |
// |               dut1 uses OCTET_DEPTH=16, PKT_SLOTS=2, DROP_CRC_FAIL=0.    |
// |               Expected octets are queued when sent and popped by a       |
// |               per-DUT monitor on every rd_valid&&rd_ready transfer.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_btle_rx_pkt_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        hit0 = 0, ov0 = 0, de0 = 0, crc0 = 0, hit1 = 0, ov1 = 0, de1 = 0, crc1 = 0;
  logic [7:0]  oct0 = 0, oct1 = 0;
  logic [15:0] dc0, dc1;
  logic        of0, of1;
  logic        rdy0 = 0, rdy1 = 0, rand0 = 0, rdy_rand0 = 0;

  btle_rx_pkt_buffer_if rif0 ();
  btle_rx_pkt_buffer_if rif1 ();

  assign rif0.rd_ready = rand0 ? rdy_rand0 : rdy0;
  assign rif1.rd_ready = rdy1;

  btle_rx_pkt_buffer #(.OCTET_DEPTH(256), .PKT_SLOTS(4), .DROP_CRC_FAIL(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .hit_flag(hit0), .octet(oct0), .octet_valid(ov0),
    .decode_end(de0), .crc_ok(crc0), .rd_if(rif0), .drop_count(dc0), .overflow(of0));

  btle_rx_pkt_buffer #(.OCTET_DEPTH(16), .PKT_SLOTS(2), .DROP_CRC_FAIL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .hit_flag(hit1), .octet(oct1), .octet_valid(ov1),
    .decode_end(de1), .crc_ok(crc1), .rd_if(rif1), .drop_count(dc1), .overflow(of1));

  typedef struct {
    logic [7:0] oct;
    logic       last;
    logic [7:0] len;
    logic       crc;
  } exp_t;

  exp_t       exp0[$], exp1[$];
  exp_t       e0, e1;
  logic [7:0] pkt[$];
  int         vectors = 0, miscompares = 0;
  logic       hold0 = 0, hold1 = 0;
  logic [7:0] held0 = 0, held1 = 0;

  always @(posedge clk) if (rand0) begin #1; rdy_rand0 = ($urandom_range(0, 3) != 0); end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && hold0) begin
      vectors++;
      if (rif0.rd_valid !== 1'b1 || rif0.rd_octet !== held0) begin
        miscompares++;
        $display("FAIL hold0 valid=%b octet=%h, required valid=1 octet=%h", rif0.rd_valid, rif0.rd_octet, held0);
      end
    end
    if (rst_n && rif0.rd_valid && rif0.rd_ready) begin
      vectors++;
      if (exp0.size() == 0) begin
        miscompares++;
        $display("FAIL xfer0 unexpected octet=%h, required none", rif0.rd_octet);
      end else begin
        e0 = exp0.pop_front();
        if (rif0.rd_octet !== e0.oct || rif0.rd_last !== e0.last || rif0.pkt_len !== e0.len || rif0.pkt_crc_ok !== e0.crc) begin
          miscompares++;
          $display("FAIL xfer0 got oct=%h last=%b len=%0d crc=%b, required oct=%h last=%b len=%0d crc=%b",
                   rif0.rd_octet, rif0.rd_last, rif0.pkt_len, rif0.pkt_crc_ok, e0.oct, e0.last, e0.len, e0.crc);
        end
      end
    end
    hold0 = rst_n && rif0.rd_valid && !rif0.rd_ready;
    held0 = rif0.rd_octet;
  end

  always @(negedge clk) begin
    if (rst_n && hold1) begin
      vectors++;
      if (rif1.rd_valid !== 1'b1 || rif1.rd_octet !== held1) begin
        miscompares++;
        $display("FAIL hold1 valid=%b octet=%h, required valid=1 octet=%h", rif1.rd_valid, rif1.rd_octet, held1);
      end
    end
    if (rst_n && rif1.rd_valid && rif1.rd_ready) begin
      vectors++;
      if (exp1.size() == 0) begin
        miscompares++;
        $display("FAIL xfer1 unexpected octet=%h, required none", rif1.rd_octet);
      end else begin
        e1 = exp1.pop_front();
        if (rif1.rd_octet !== e1.oct || rif1.rd_last !== e1.last || rif1.pkt_len !== e1.len || rif1.pkt_crc_ok !== e1.crc) begin
          miscompares++;
          $display("FAIL xfer1 got oct=%h last=%b len=%0d crc=%b, required oct=%h last=%b len=%0d crc=%b",
                   rif1.rd_octet, rif1.rd_last, rif1.pkt_len, rif1.pkt_crc_ok, e1.oct, e1.last, e1.len, e1.crc);
        end
      end
    end
    hold1 = rst_n && rif1.rd_valid && !rif1.rd_ready;
    held1 = rif1.rd_octet;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv(input int d, input logic h, input logic v, input logic [7:0] o,
                     input logic de, input logic c);
    if (d == 0) begin hit0 = h; ov0 = v; oct0 = o; de0 = de; crc0 = c; end
    else        begin hit1 = h; ov1 = v; oct1 = o; de1 = de; crc1 = c; end
    tick(1);
    if (d == 0) begin hit0 = 0; ov0 = 0; oct0 = 0; de0 = 0; crc0 = 0; end
    else        begin hit1 = 0; ov1 = 0; oct1 = 0; de1 = 0; crc1 = 0; end
  endtask

  // Sends the octets in pkt; decode_end either with the last octet or alone.
  task automatic send_pkt(input int d, input logic crc, input bit keep, input bit sep_end);
    int   n = pkt.size();
    exp_t e;
    drv(d, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      drv(d, 1'b0, 1'b1, pkt[i], (!sep_end && i == n - 1), crc);
      if (keep) begin
        e.oct = pkt[i]; e.last = (i == n - 1); e.len = 8'(n); e.crc = crc;
        if (d == 0) exp0.push_back(e); else exp1.push_back(e);
      end
    end
    if (sep_end) drv(d, 1'b0, 1'b0, 8'h00, 1'b1, crc);
  endtask

  task automatic wait_drain(input int d, input int limit);
    int k = 0;
    while (k < limit && ((d == 0) ? (exp0.size() != 0 || rif0.pkt_avail) : (exp1.size() != 0 || rif1.pkt_avail))) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= limit) begin
      miscompares++;
      $display("FAIL drain%0d timeout left=%0d, required 0", d, (d == 0) ? exp0.size() : exp1.size());
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    vectors++;
    if ({rif0.pkt_avail, rif0.pkt_len, rif0.pkt_crc_ok, rif0.rd_octet, rif0.rd_valid, rif0.rd_last, dc0, of0} !== '0) begin
      miscompares++;
      $display("FAIL reset0 outputs avail=%b len=%0d valid=%b drop=%0d ovf=%b, required all 0",
               rif0.pkt_avail, rif0.pkt_len, rif0.rd_valid, dc0, of0);
    end
    vectors++;
    if ({rif1.pkt_avail, rif1.pkt_len, rif1.pkt_crc_ok, rif1.rd_octet, rif1.rd_valid, rif1.rd_last, dc1, of1} !== '0) begin
      miscompares++;
      $display("FAIL reset1 outputs avail=%b len=%0d valid=%b drop=%0d ovf=%b, required all 0",
               rif1.pkt_avail, rif1.pkt_len, rif1.rd_valid, dc1, of1);
    end
    tick(1);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    int k = 0;
    rdy0 = 1'b1;
    pkt = {8'h40, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_pkt(0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if (rif0.pkt_avail !== 1'b1 || rif0.pkt_len !== 8'd7 || rif0.pkt_crc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_desc avail=%b len=%0d crc=%b, required 1 7 1", rif0.pkt_avail, rif0.pkt_len, rif0.pkt_crc_ok);
    end
    while (!rif0.rd_valid && k < 2) begin @(negedge clk); k++; end
    vectors++;
    if (rif0.rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency rd_valid=%b after %0d cycles, required 1", rif0.rd_valid, k);
    end
    wait_drain(0, 50);
    @(negedge clk);
    vectors++;
    if (rif0.pkt_avail !== 1'b0 || dc0 !== 16'd0) begin
      miscompares++;
      $display("FAIL basic_after avail=%b drop=%0d, required 0 0", rif0.pkt_avail, dc0);
    end
  endtask

  task automatic test_crc_drop();
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(i * 3 + 1));
    send_pkt(0, 1'b0, 1'b0, 1'b0);
    tick(3);
    @(negedge clk);
    vectors++;
    if (rif0.pkt_avail !== 1'b0 || dc0 !== 16'd1 || dut0.used_q !== '0 || of0 !== 1'b0) begin
      miscompares++;
      $display("FAIL crc_drop avail=%b drop=%0d used=%0d ovf=%b, required 0 1 0 0", rif0.pkt_avail, dc0, dut0.used_q, of0);
    end
  endtask

  task automatic test_depth_overflow();
    rdy1 = 1'b0;
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h10 + i));
    send_pkt(1, 1'b1, 1'b1, 1'b0);
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h80 + i));
    send_pkt(1, 1'b1, 1'b0, 1'b0);
    tick(2);
    @(negedge clk);
    vectors++;
    if (of1 !== 1'b1 || dc1 !== 16'd1) begin
      miscompares++;
      $display("FAIL depth_ovf ovf=%b drop=%0d, required 1 1", of1, dc1);
    end
    vectors++;
    if (rif1.pkt_avail !== 1'b1 || rif1.pkt_len !== 8'd10) begin
      miscompares++;
      $display("FAIL depth_head avail=%b len=%0d, required 1 10", rif1.pkt_avail, rif1.pkt_len);
    end
    tick(1);
    rdy1 = 1'b1;
    wait_drain(1, 100);
    @(negedge clk);
    vectors++;
    if (dut1.used_q !== '0) begin
      miscompares++;
      $display("FAIL depth_used used=%0d, required 0", dut1.used_q);
    end
    tick(1);
  endtask

  task automatic test_slots();
    rdy1 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pkt.delete();
      for (int i = 0; i < 3; i++) pkt.push_back(8'(8'hA0 + p * 16 + i));
      send_pkt(1, 1'b1, (p < 2), 1'b0);
    end
    tick(2);
    @(negedge clk);
    vectors++;
    if (rif1.pkt_avail !== 1'b1 || rif1.pkt_len !== 8'd3) begin
      miscompares++;
      $display("FAIL slots_head avail=%b len=%0d, required 1 3", rif1.pkt_avail, rif1.pkt_len);
    end
    tick(1);
    rdy1 = 1'b1;
    wait_drain(1, 100);
  endtask

  task automatic test_crc_keep();
    logic [15:0] dc_before = dc1;
    rdy1 = 1'b0;
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h5A ^ i));
    send_pkt(1, 1'b0, 1'b1, 1'b0);
    tick(2);
    @(negedge clk);
    vectors++;
    if (rif1.pkt_avail !== 1'b1 || rif1.pkt_len !== 8'd10 || rif1.pkt_crc_ok !== 1'b0 || dc1 !== dc_before) begin
      miscompares++;
      $display("FAIL crc_keep avail=%b len=%0d crc=%b drop=%0d, required 1 10 0 %0d",
               rif1.pkt_avail, rif1.pkt_len, rif1.pkt_crc_ok, dc1, dc_before);
    end
    tick(1);
    rdy1 = 1'b1;
    wait_drain(1, 100);
  endtask

  task automatic test_back_to_back();
    rdy0 = 1'b1;
    pkt.delete();
    for (int i = 0; i < 243; i++) pkt.push_back(8'($urandom));
    send_pkt(0, 1'b1, 1'b1, 1'b0);
    wait_drain(0, 400);
    @(negedge clk);
    vectors++;
    if (dut0.wr_ptr_q !== 8'd250) begin
      miscompares++;
      $display("FAIL b2b_start wr_ptr=%0d, required 250", dut0.wr_ptr_q);
    end
    tick(1);
    rand0 = 1'b1;
    for (int p = 0; p < 8; p++) begin
      pkt.delete();
      for (int i = 0; i < 12; i++) pkt.push_back(8'($urandom));
      send_pkt(0, 1'b1, 1'b1, 1'b0);
      tick(10);
    end
    wait_drain(0, 600);
    rand0 = 1'b0;
    @(negedge clk);
    vectors++;
    if (dc0 !== 16'd1 || of0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drops drop=%0d ovf=%b, required 1 0", dc0, of0);
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    rdy0 = 1'b0;
    pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(0, 1'b1, 1'b1, 1'b0);
    drv(0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drv(0, 1'b0, 1'b1, 8'(8'hF0 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rif0.pkt_avail, rif0.pkt_len, rif0.pkt_crc_ok, rif0.rd_octet, rif0.rd_valid, rif0.rd_last, dc0, of0} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid outputs avail=%b len=%0d valid=%b drop=%0d ovf=%b, required all 0",
               rif0.pkt_avail, rif0.pkt_len, rif0.rd_valid, dc0, of0);
    end
    exp0.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    rdy0 = 1'b1;
    pkt = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    send_pkt(0, 1'b1, 1'b1, 1'b0);
    wait_drain(0, 50);
    @(negedge clk);
    vectors++;
    if (dc0 !== 16'd0 || of0 !== 1'b0 || rif0.pkt_avail !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after drop=%0d ovf=%b avail=%b, required 0 0 0", dc0, of0, rif0.pkt_avail);
    end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_drop();
    test_depth_overflow();
    test_slots();
    test_crc_keep();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
